fpu_add_arbiter: RTL and testbench

FPU_ADD_ARBITER -- requirements
Module: fpu_add_arbiter

---
 rtl/fpu_add_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_fpu_add_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: two-requester front end for a fixed-latency FP adder.
// Grants one request at a time (round-robin, or fixed priority to
// requester 0 when FPU_ARB_FIXED_PRIO_EN is defined), holds operands
// stable for the adder, pulses add_start for START_LEN cycles, waits
// ADDER_LAT cycles, then presents the result on a valid/ready response.
// Optional build macro: FPU_ARB_FIXED_PRIO_EN (fixed priority, pointer unused).
module fpu_add_arbiter #(
  parameter int ADDER_LAT = 20,  // 1..255
  parameter int START_LEN = 2    // 1..15
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req0_mode,
  input  logic        req1_mode,
  output logic [31:0] add_A,
  output logic [31:0] add_B,
  output logic        add_mode,
  output logic        add_start,
  input  logic [31:0] add_Product,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  start_cnt_r;
  logic [7:0]  wait_cnt_r;
  logic        start_last_s;
  logic        wait_last_s;
  logic        grant0_s;
  logic        grant1_s;
  logic        accept_s;
  logic        accept_id_s;

  assign start_last_s = (start_cnt_r == 4'(START_LEN - 1));
  assign wait_last_s  = (wait_cnt_r == 8'(ADDER_LAT - 1));
  assign accept_s     = req0_ready | req1_ready;
  assign accept_id_s  = req1_ready;

`ifdef FPU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 always wins when both are valid.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end
`else
  logic last_grant_r;  // 1 = requester 1 was granted last

  // Round-robin: on a tie, the requester not granted last wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Last-grant pointer, updated on every accepted request.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= accept_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // State register.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_START;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (start_last_s) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_WAIT: begin
        if (wait_last_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State-decoded outputs: ready is only offered while idle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b1;
    case (state_r)
      ST_IDLE: begin
        req0_ready = grant0_s;
        req1_ready = grant1_s;
        busy       = 1'b0;
      end
      ST_START, ST_WAIT, ST_RESP: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b1;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  // Phase counters for the start pulse and the adder latency window.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      start_cnt_r <= 4'd0;
      wait_cnt_r  <= 8'd0;
    end else begin
      if (state_r == ST_START && !start_last_s) begin
        start_cnt_r <= start_cnt_r + 4'd1;
      end else begin
        start_cnt_r <= 4'd0;
      end
      if (state_r == ST_WAIT && !wait_last_s) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
    end
  end

  // Registered datapath: operand capture on accept, result capture at end of WAIT.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      add_A     <= 32'd0;
      add_B     <= 32'd0;
      add_mode  <= 1'b0;
      add_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      add_start <= (next_state_s == ST_START);
      rsp_valid <= (next_state_s == ST_RESP);
      if (accept_s) begin
        add_A    <= accept_id_s ? req1_a : req0_a;
        add_B    <= accept_id_s ? req1_b : req0_b;
        add_mode <= accept_id_s ? req1_mode : req0_mode;
        rsp_id   <= accept_id_s;
      end else begin
        add_A    <= add_A;
        add_B    <= add_B;
        add_mode <= add_mode;
        rsp_id   <= rsp_id;
      end
      if (state_r == ST_WAIT && wait_last_s) begin
        rsp_data <= add_Product;
      end else begin
        rsp_data <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Self-checking bench for fpu_add_arbiter: fixed-latency adder stub,
// transaction-level arbitration/latency model, directed and random ops.
module tb_fpu_add_arbiter;

  localparam int ADDER_LAT = 20;
  localparam int START_LEN = 2;
  localparam int LAT       = START_LEN + ADDER_LAT + 1;
  localparam int NEVER     = 32'h3FFF_FFFF;

  logic        Clock;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_mode, req1_mode;
  logic [31:0] add_A, add_B;
  logic        add_mode, add_start;
  logic [31:0] add_Product;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic        busy;

  int checks   = 0;
  int errors   = 0;
  int last_win = 1;

  fpu_add_arbiter #(.ADDER_LAT(ADDER_LAT), .START_LEN(START_LEN)) dut (
    .Clock(Clock), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .add_A(add_A), .add_B(add_B), .add_mode(add_mode), .add_start(add_start),
    .add_Product(add_Product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Adder stub result: one known fp32 sum, otherwise an arbitrary mix.
  function automatic logic [31:0] add_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic m);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && m == 1'b0) return 32'h4040_0000;
    return (a + b) ^ {m, 31'd0};
  endfunction

  // Expected winner from the arbitration rule.
  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef FPU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last_win == 1) ? 0 : 1;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  // Adder model: result valid ADDER_LAT cycles after the first add_start cycle.
  int nc = 0;
  int first_cyc = NEVER;
  logic prev_start = 1'b0;
  always @(negedge Clock) begin
    nc = nc + 1;
    if (!reset) begin
      first_cyc  = NEVER;
      prev_start = 1'b0;
    end else begin
      if (add_start && !prev_start) first_cyc = nc;
      prev_start = add_start;
    end
    add_Product = (nc >= first_cyc + ADDER_LAT) ? add_fn(add_A, add_B, add_mode)
                                                : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_add_start"}, {31'd0, add_start}, 32'd0);
    chk({tag, "_add_A"}, add_A, 32'd0);
    chk({tag, "_add_B"}, add_B, 32'd0);
    chk({tag, "_add_mode"}, {31'd0, add_mode}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // One complete operation; valids stay high throughout to prove they are ignored.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0, input logic m0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic m1,
                        input int hold);
    int win, starts, held;
    bit seen, done;
    logic [31:0] ea, eb, ed;
    logic em;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_mode = m0;
    req1_a = a1; req1_b = b1; req1_mode = m1;
    #1;
    win = pick(v0, v1);
    chk("grant_ready0", {31'd0, req0_ready}, 32'(win == 0));
    chk("grant_ready1", {31'd0, req1_ready}, 32'(win == 1));
    ea = win ? a1 : a0;
    eb = win ? b1 : b0;
    em = win ? m1 : m0;
    ed = add_fn(ea, eb, em);
    @(posedge Clock); #1;
    last_win = win;
    starts = 0; held = 0; seen = 0; done = 0;
    for (int n = 1; n <= LAT + hold + 4 && !done; n++) begin
      starts += int'(add_start);
      chk("add_A_stable", add_A, ea);
      chk("add_B_stable", add_B, eb);
      chk("add_mode_stable", {31'd0, add_mode}, {31'd0, em});
      chk("no_ready_busy", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("busy_high", {31'd0, busy}, 32'd1);
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1;
          chk("rsp_latency", n, LAT);
        end
        chk("rsp_data", rsp_data, ed);
        chk("rsp_id", {31'd0, rsp_id}, 32'(win));
        if (held == hold) rsp_ready = 1'b1;
        else held++;
      end
      @(posedge Clock); #1;
      if (rsp_ready) begin
        rsp_ready = 1'b0;
        done = 1;
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    chk("start_len", starts, START_LEN);
    chk("idle_after_rsp_busy", {31'd0, busy}, 32'd0);
    chk("idle_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    int v0, v1;
    reset = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    req0_mode = 1'b0; req1_mode = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk_reset_vals("reset");
    reset = 1'b1;
    @(posedge Clock); #1;

    // Directed fp32 add from requester 0.
    run_op(1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0,
           32'h0, 32'h0, 1'b0, 0);

    // Fresh reset, then simultaneous requests twice (tie-break order).
    reset = 1'b0; #1;
    chk_reset_vals("reset2");
    last_win = 1;
    @(posedge Clock); #1;
    reset = 1'b1;
    @(posedge Clock); #1;
    run_op(1'b1, 1'b1, 32'h1111_0000, 32'h2222_0000, 1'b1,
           32'h3333_0000, 32'h4444_0000, 1'b0, 0);
    run_op(1'b1, 1'b1, 32'h5555_0000, 32'h6666_0000, 1'b0,
           32'h7777_0000, 32'h0888_0000, 1'b1, 0);

    // Response back-pressure for 5 cycles.
    run_op(1'b0, 1'b1, 32'h0, 32'h0, 1'b0,
           32'h4120_0000, 32'h40A0_0000, 1'b0, 5);

    // Valid raised then dropped in IDLE before the clock edge: no operation.
    req0_valid = 1'b1; req0_a = 32'hAAAA_5555; #1;
    chk("drop_ready_seen", {31'd0, req0_ready}, 32'd1);
    #2 req0_valid = 1'b0;
    @(posedge Clock); #1;
    chk("drop_no_busy", {31'd0, busy}, 32'd0);
    chk("drop_no_start", {31'd0, add_start}, 32'd0);

    // Reset asserted during WAIT cycle 10.
    req0_valid = 1'b1; req0_a = 32'h0102_0304; req0_b = 32'h0506_0708; req0_mode = 1'b1;
    @(posedge Clock); #1;
    req0_valid = 1'b0;
    repeat (START_LEN + 9) @(posedge Clock);
    #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0; #1;
    chk_reset_vals("midop_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      chk("midop_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    last_win = 1;
    reset = 1'b1;
    @(posedge Clock); #1;
    run_op(1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0,
           32'h9999_0000, 32'h8888_0000, 1'b1, 1);

    // Randomized operations.
    for (int k = 0; k < 8; k++) begin
      v0 = $urandom_range(0, 1);
      v1 = (v0 == 0) ? 1 : $urandom_range(0, 1);
      run_op(v0[0], v1[0], $urandom, $urandom, 1'($urandom_range(0, 1)),
             $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
